uart_rx_ctrl: RTL and testbench

UART receive sequencer that drives the baud generator (uart_clk_gen) and frames incoming serial data.
- Synchronises the rx line and detects the start-bit falling edge.
- Pulses uart_start to re-phase the baud generator, then samples start, data, optional parity and stop bits on each uart_ce.
- Delivers each byte with error flags over a valid/ready handshake to the register/FIFO layer.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_e      : receive sequencer states
//   UART_DATA_W_MAX : widest supported data word
//   PARITY_EVEN/ODD : encoding of the parity-sense configuration bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int UART_DATA_W_MAX = 8;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Input synchroniser and falling-edge detector for the serial rx line.
// Every flop resets to 1 so that a reset is seen as an idle (high) line.
//   clk, rstb      : clock, asynchronous active-low reset
//   rx_i           : asynchronous serial input
//   rx_s_o         : synchronised line level
//   fall_edge_o    : high for one cycle when rx_s_o goes 1 -> 0
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstb,
  input  logic rx_i,
  output logic rx_s_o,
  output logic fall_edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rx_s_o      = sync_q[SYNC_STAGES-1];
  assign fall_edge_o = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer. Detects the start edge, re-phases the baud
// generator with uart_start, samples start/data/(parity)/stop bits on
// uart_ce and hands each word plus error flags to the consumer over a
// valid/ready handshake.
// Build option: define UART_RX_PARITY_EN to build the parity bit state and
// parity check; without it cfg_parity_en/cfg_parity_odd are ignored and
// rx_parity_err is tied low.
//   clk, rstb                      : clock, asynchronous active-low reset
//   cfg_enable                     : receiver enable (0 forces IDLE)
//   cfg_parity_en, cfg_parity_odd  : parity config, sampled at frame start
//   uart_rx                        : serial line, idle high
//   uart_ce                        : bit-centre tick from the baud generator
//   uart_start                     : one-cycle baud generator re-phase pulse
//   rx_data, rx_valid, rx_ready    : received word handshake
//   rx_frame_err, rx_parity_err,
//   rx_break                       : flags qualified by rx_valid
//   rx_overrun                     : pulse when a completed frame is dropped
//   rx_busy                        : sequencer not idle
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              cfg_enable,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              uart_rx,
  input  logic              uart_ce,
  output logic              uart_start,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_frame_err,
  output logic              rx_parity_err,
  output logic              rx_break,
  output logic              rx_overrun,
  output logic              rx_busy
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  if (DATA_W < 5 || DATA_W > UART_DATA_W_MAX) begin : g_bad_width
    $error("uart_rx_ctrl: DATA_W must be 5..8");
  end

  logic rx_s;
  logic fall_edge;

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rstb        (rstb),
    .rx_i        (uart_rx),
    .rx_s_o      (rx_s),
    .fall_edge_o (fall_edge)
  );

  rx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              ferr_q, ferr_d;
  logic              brk_q, brk_d;
  logic              ovr_q, ovr_d;
  logic              start_q, start_d;
  logic              stop_ferr, stop_brk;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_odd_q, par_odd_d;
  logic par_bit_q, par_bit_d;
  logic par_err_q, par_err_d;
  logic perr_q, perr_d;
`else
  logic unused_cfg;
  assign unused_cfg = cfg_parity_en ^ cfg_parity_odd;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;
    ovr_d      = 1'b0;
    start_d    = 1'b0;
    stop_ferr  = ~rx_s;
`ifdef UART_RX_PARITY_EN
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    perr_d     = perr_q;
    // par_bit_q is cleared at frame start, so it reads 0 when parity is off
    stop_brk   = ~rx_s & (shift_q == '0) & ~par_bit_q;
`else
    stop_brk   = ~rx_s & (shift_q == '0);
`endif

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (!cfg_enable) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            start_d   = 1'b1;
            state_d   = START;
`ifdef UART_RX_PARITY_EN
            par_en_d  = cfg_parity_en;
            par_odd_d = cfg_parity_odd;
            par_bit_d = 1'b0;
            par_err_d = 1'b0;
`endif
          end
        end
        START: begin
          if (uart_ce) begin
            // A high line at the start-bit centre was a glitch: drop silently
            state_d = rx_s ? IDLE : DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          if (uart_ce) begin
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = par_en_q ? PARITY : STOP;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (uart_ce) begin
            par_bit_d = rx_s;
            par_err_d = ((^shift_q) ^ rx_s) != par_odd_q;
            state_d   = STOP;
          end
        end
`endif
        STOP: begin
          if (uart_ce) begin
            // Accept in the completion cycle frees the slot for the new word
            if (!rx_valid_q || rx_ready) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              ferr_d     = stop_ferr;
              brk_d      = stop_brk;
`ifdef UART_RX_PARITY_EN
              perr_d     = par_err_q;
`endif
            end else begin
              ovr_d = 1'b1;
            end
            // A low stop bit may be a held break; wait for idle before rearming
            state_d = stop_ferr ? WAIT_HIGH : IDLE;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
      start_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
      start_q    <= start_d;
`ifdef UART_RX_PARITY_EN
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      perr_q     <= perr_d;
`endif
    end
  end

  assign uart_start   = start_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_break     = brk_q;
  assign rx_overrun   = ovr_q;
  assign rx_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: serial frames at 16 clk/bit, a simple baud tick
// model, expected words queued at stimulus time and checked by a monitor.
module tb_uart_rx_ctrl;

  localparam int DW       = 8;
  localparam int SS       = 2;
  localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          cfg_enable = 1'b0;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          uart_rx = 1'b1;
  logic          uart_ce = 1'b0;
  logic          rx_ready = 1'b0;
  logic          uart_start;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_frame_err;
  logic          rx_parity_err;
  logic          rx_break;
  logic          rx_overrun;
  logic          rx_busy;

  uart_rx_ctrl #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .cfg_enable     (cfg_enable),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .uart_rx        (uart_rx),
    .uart_ce        (uart_ce),
    .uart_start     (uart_start),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .rx_frame_err   (rx_frame_err),
    .rx_parity_err  (rx_parity_err),
    .rx_break       (rx_break),
    .rx_overrun     (rx_overrun),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ferr;
    logic          perr;
    logic          brk;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   start_seen = 0;
  int   start_exp = 0;
  int   ovr_seen = 0;
  int   ovr_exp = 0;
  bit   rand_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Baud generator model: first tick half a bit after re-phase, then every bit.
  initial begin
    int  bcnt;
    bit  run;
    bcnt = 0;
    run  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstb || !cfg_enable) begin
        run = 1'b0; uart_ce = 1'b0;
      end else if (uart_start) begin
        run = 1'b1; bcnt = BIT_CLKS/2 - 1; uart_ce = 1'b0;
      end else if (run && bcnt == 0) begin
        uart_ce = 1'b1; bcnt = BIT_CLKS - 1;
      end else begin
        uart_ce = 1'b0;
        if (run) bcnt--;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: counts pulses and checks every accepted word against the queue.
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (rstb) begin
        if (uart_start) start_seen++;
        if (rx_overrun) ovr_seen++;
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h required=none", rx_data);
          end else begin
            e = exp_q.pop_front();
            chk("rx_data", 32'(rx_data), 32'(e.data));
            chk("flags{ferr,perr,brk}", {29'd0, rx_frame_err, rx_parity_err, rx_break},
                {29'd0, e.ferr, e.perr, e.brk});
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  // Sends one frame; the expected outcome is derived from the frame content.
  task automatic send_frame(input logic [DW-1:0] d, input bit pen, input bit podd,
                            input bit pbit, input bit stop, input int extra_low,
                            input bit expect_word);
    rec_t e;
    bit   sent_par;
    sent_par       = PAR_BUILT && pen;
    cfg_parity_en  = pen;
    cfg_parity_odd = podd;
    e.data = d;
    e.ferr = !stop;
    e.perr = sent_par ? (((^d) ^ pbit) != podd) : 1'b0;
    e.brk  = !stop && (d == '0) && (!sent_par || !pbit);
    if (expect_word) exp_q.push_back(e);
    else ovr_exp++;
    start_exp++;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (sent_par) drive_bit(pbit);
    drive_bit(stop);
    for (int i = 0; i < extra_low; i++) drive_bit(1'b0);
    drive_bit(1'b1);
  endtask

  initial begin
    logic [DW-1:0] d;
    bit            pen, podd, pbit, stop;
    rec_t          e;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rx_valid", 32'(rx_valid), 0);
    chk("reset_rx_data", 32'(rx_data), 0);
    chk("reset_uart_start", 32'(uart_start), 0);
    chk("reset_rx_busy", 32'(rx_busy), 0);
    chk("reset_flags", {27'd0, rx_frame_err, rx_parity_err, rx_break, rx_overrun, 1'b0}, 0);
    rstb = 1'b1;
    cfg_enable = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Clean 8N1 frame
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    chk("start_count_a5", 32'(start_seen), 32'(start_exp));

    // Parity frames: even with parity bit 1 is an error, odd is clean
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1'b1);

    // Framing error with the line held low afterwards: no re-trigger
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1);
    chk("start_count_ferr", 32'(start_seen), 32'(start_exp));

    // Break: line low for 20 bit times yields exactly one word
    cfg_parity_en = 1'b0;
    e = '{data: '0, ferr: 1'b1, perr: 1'b0, brk: 1'b1};
    exp_q.push_back(e);
    start_exp++;
    uart_rx = 1'b0;
    repeat (20 * BIT_CLKS) @(posedge clk);
    #1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("start_count_break", 32'(start_seen), 32'(start_exp));
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);

    // 6-clk glitch: one uart_start at SYNC_STAGES+1 cycles, then false start
    start_exp++;
    uart_rx = 1'b0;
    for (int i = 0; i < SS + 1; i++) begin
      @(negedge clk);
      chk("glitch_start_early", 32'(uart_start), 0);
    end
    @(negedge clk);
    chk("glitch_start_latency", 32'(uart_start), 1);
    repeat (3) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_busy", 32'(rx_busy), 0);
    chk("glitch_valid", 32'(rx_valid), 0);

    // Randomised frames with a randomly stalling consumer
    rand_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      d    = ($urandom_range(0, 4) == 0) ? '0 : DW'($urandom);
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      pbit = (^d) ^ podd ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 5) != 0);
      send_frame(d, pen, podd, pbit, stop, 0, 1'b1);
    end
    rand_ready = 1'b0;
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Overrun: two frames with no consumer
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    chk("ovr_valid_held", 32'(rx_valid), 1);
    chk("ovr_data_held", 32'(rx_data), 32'h11);
    chk("ovr_pulse_count", 32'(ovr_seen), 32'(ovr_exp));
    rx_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("ovr_drained", 32'(rx_valid), 0);

    // Disable mid-frame: back to idle, no word
    start_exp++;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    cfg_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("disable_busy", 32'(rx_busy), 0);
    uart_rx = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    cfg_enable = 1'b1;
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("disable_no_word", 32'(rx_valid), 0);

    // Reset mid-frame: immediate idle, partial frame lost
    start_exp++;
    drive_bit(1'b0);
    drive_bit(1'b1);
    rstb = 1'b0;
    #1;
    chk("midreset_busy", 32'(rx_busy), 0);
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstb = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1);
    repeat (8) @(posedge clk);
    #1;

    chk("final_start_count", 32'(start_seen), 32'(start_exp));
    chk("final_overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
